// File: rtl/ksa_pkg.sv
// Shared types and helpers for the multi-word Kogge-Stone adder.
// Holds word width, FSM state enum and the word-select helper.
package ksa_pkg;

  localparam int WORD_W    = 16;
  // Upper bound on words per operand that word_sel can address.
  localparam int MAX_WORDS = 64;
  localparam int MAX_W     = WORD_W * MAX_WORDS;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  // Pick word i (LSW = 0) out of a zero-extended operand.
  function automatic logic [WORD_W-1:0] word_sel(
    input logic [MAX_W-1:0] v,
    input int               i
  );
    return v[i*WORD_W +: WORD_W];
  endfunction

endpackage

// File: rtl/ksa_16bit.sv
// 16-bit Kogge-Stone adder, purely combinational.
// Ports: a, b, ci in; s (sum), co (carry out) out.
module ksa_16bit
  import ksa_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              ci,
  output logic [WORD_W-1:0] s,
  output logic              co
);

  logic [WORD_W-1:0] p0;
  logic [WORD_W-1:0] g0, g1, g2, g3, g4;
  logic [WORD_W-1:0] pp0, pp1, pp2, pp3;

  assign p0 = a ^ b;

  // Carry-in folded into bit 0 generate, so every
  // prefix G[i] is the carry into bit i+1.
  assign g0  = (a & b) | {{(WORD_W-1){1'b0}}, p0[0] & ci};
  assign pp0 = p0;

  // Prefix levels with spans 1, 2, 4, 8. Low bits shift
  // in G=0 / P=1 so they pass through unchanged.
  assign g1  = g0 | (pp0 & (g0 << 1));
  assign pp1 = pp0 & ~(~pp0 << 1);
  assign g2  = g1 | (pp1 & (g1 << 2));
  assign pp2 = pp1 & ~(~pp1 << 2);
  assign g3  = g2 | (pp2 & (g2 << 4));
  assign pp3 = pp2 & ~(~pp2 << 4);
  assign g4  = g3 | (pp3 & (g3 << 8));

  assign s  = p0 ^ {g4[WORD_W-2:0], ci};
  assign co = g4[WORD_W-1];

endmodule

// File: rtl/ksa_wide_seq.sv
// Sequential 16*WORDS-bit add/sub, one ksa_16bit word per cycle.
// Ports: in_valid/in_ready + a,b,ci,sub in; out_valid/out_ready + sum,co,ovf out.
module ksa_wide_seq
  import ksa_pkg::*;
#(
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_W*WORDS-1:0] a,
  input  logic [WORD_W*WORDS-1:0] b,
  input  logic                  ci,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_W*WORDS-1:0] sum,
  output logic                  co,
  output logic                  ovf
);

  localparam int W  = WORD_W * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          carry_q, carry_d;
  logic          co_q, co_d;
  logic          ovf_q, ovf_d;
  logic          ovld_q, ovld_d;
  logic          irdy_q, irdy_d;

  logic [WORD_W-1:0] aw, bw, sw;
  logic              cw;
  int                pos;

  assign pos = 32'(idx_q);
  assign aw  = word_sel(MAX_W'(a_q), pos);
  assign bw  = word_sel(MAX_W'(b_q), pos);

  ksa_16bit u_add (
    .a  (aw),
    .b  (bw),
    .ci (carry_q),
    .s  (sw),
    .co (cw)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    ovld_d  = ovld_q;
    irdy_d  = irdy_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          // Subtract as A + ~B + 1.
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : ci;
          idx_d   = '0;
          irdy_d  = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[pos*WORD_W +: WORD_W] = sw;
        carry_d = cw;
        if (idx_q == LAST) begin
          co_d    = cw;
          ovf_d   = (aw[WORD_W-1] == bw[WORD_W-1])
                 && (sw[WORD_W-1] != aw[WORD_W-1]);
          idx_d   = '0;
          ovld_d  = 1'b1;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) begin
          ovld_d  = 1'b0;
          irdy_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        ovld_d  = 1'b0;
        irdy_d  = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      ovld_q  <= 1'b0;
      irdy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      ovld_q  <= ovld_d;
      irdy_q  <= irdy_d;
    end
  end

  assign in_ready  = irdy_q;
  assign out_valid = ovld_q;
  assign sum       = sum_q;
  assign co        = co_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_ksa_wide_seq.sv
// Randomized self-checking bench for ksa_wide_seq (WORDS=4).
// Reference: 65-bit integer add of a, (sub ? ~b : b), carry.
module tb_ksa_wide_seq;

  localparam int WORDS = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        ci = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] sum;
  logic        co;
  logic        ovf;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ksa_wide_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .co        (co),
    .ovf       (ovf)
  );

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model(input logic [63:0] ma, input logic [63:0] mb,
                       input logic mci, input logic msub,
                       output logic [63:0] es, output logic ec,
                       output logic eo);
    logic [63:0] bp;
    logic [64:0] full;
    bp   = msub ? ~mb : mb;
    full = {1'b0, ma} + {1'b0, bp} + 65'(msub ? 1'b1 : mci);
    es   = full[63:0];
    ec   = full[64];
    eo   = (ma[63] == bp[63]) && (es[63] != ma[63]);
  endtask

  // Called at a negedge with the DUT idle; returns at a negedge.
  task automatic run_op(input string tag, input logic [63:0] ta,
                        input logic [63:0] tb, input logic tci,
                        input logic tsub, input int hold);
    logic [63:0] es, ss;
    logic        ec, eo, sc, so;
    int          lat;
    model(ta, tb, tci, tsub, es, ec, eo);
    chk({tag, ".in_ready"}, 64'(in_ready), 64'd1);
    a = ta; b = tb; ci = tci; sub = tsub; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    a = $urandom; b = $urandom;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!out_valid && in_ready) begin
        chk({tag, ".busy_rdy"}, 64'(in_ready), 64'd0);
      end
    end while (!out_valid && lat < 30);
    chk({tag, ".latency"}, 64'(lat), 64'(WORDS + 1));
    chk({tag, ".sum"}, sum, es);
    chk({tag, ".co"}, 64'(co), 64'(ec));
    chk({tag, ".ovf"}, 64'(ovf), 64'(eo));
    chk({tag, ".rdy_done"}, 64'(in_ready), 64'd0);
    ss = sum; sc = co; so = ovf;
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      @(negedge clk);
      chk({tag, ".hold_vld"}, 64'(out_valid), 64'd1);
      chk({tag, ".hold_rdy"}, 64'(in_ready), 64'd0);
      chk({tag, ".hold_sum"}, sum, ss);
      chk({tag, ".hold_flags"}, {62'd0, co, ovf}, {62'd0, sc, so});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, ".vld_low"}, 64'(out_valid), 64'd0);
    chk({tag, ".rdy_back"}, 64'(in_ready), 64'd1);
  endtask

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        ci;
    logic        sub;
  } vec_t;

  vec_t dir [7];

  initial begin
    dir[0] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0};
    dir[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0};
    dir[2] = '{64'd5, 64'd7, 1'b0, 1'b1};
    dir[3] = '{64'd7, 64'd5, 1'b1, 1'b1};
    dir[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0};
    dir[5] = '{64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1};
    dir[6] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001,
               1'b1, 1'b0};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.sum", sum, 64'd0);
    chk("rst.flags", {62'd0, co, ovf}, 64'd0);

    // Fixed expectations straight from the arithmetic.
    run_op("inc16", dir[0].a, dir[0].b, dir[0].ci, dir[0].sub, 0);
    chk("inc16.const", sum, 64'h0000_0000_0001_0000);
    run_op("ripple", dir[1].a, dir[1].b, dir[1].ci, dir[1].sub, 0);
    chk("ripple.const", {sum[62:0], co}, 64'd1);
    run_op("sub57", dir[2].a, dir[2].b, dir[2].ci, dir[2].sub, 0);
    chk("sub57.const", sum, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("sub75", dir[3].a, dir[3].b, dir[3].ci, dir[3].sub, 0);
    chk("sub75.const", {sum[62:0], co}, 64'd5);
    run_op("povf", dir[4].a, dir[4].b, dir[4].ci, dir[4].sub, 0);
    chk("povf.const", {sum[62:0], ovf}, 64'd1);
    run_op("novf", dir[5].a, dir[5].b, dir[5].ci, dir[5].sub, 0);
    chk("novf.const", {60'd0, sum[63], sum[0], ovf, co},
        64'b0111);
    run_op("mid", dir[6].a, dir[6].b, dir[6].ci, dir[6].sub, 0);

    // Result held under backpressure with in_valid noise.
    run_op("hold", 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321,
           1'b1, 1'b0, 10);
    // Back-to-back accept right after the handshake.
    run_op("b2b", 64'd100, 64'd23, 1'b0, 1'b1, 0);

    // Reset mid-RUN with idx=2 discards the operation.
    a = 64'hDEAD_BEEF_0000_1111; b = 64'h1111; sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mrst.in_ready", 64'(in_ready), 64'd1);
    chk("mrst.sum", sum, 64'd0);
    chk("mrst.flags", {62'd0, co, ovf}, 64'd0);
    begin
      int seen = 0;
      repeat (8) begin
        @(negedge clk);
        if (out_valid) seen++;
      end
      chk("mrst.no_out", 64'(seen), 64'd0);
    end
    run_op("after_rst", 64'd3, 64'd4, 1'b0, 1'b0, 0);
    chk("after_rst.const", sum, 64'd7);

    for (int k = 0; k < 40; k++) begin
      logic [63:0] ra, rb;
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (k % 8 == 1) ra = 64'hFFFF_FFFF_FFFF_FFFF;
      if (k % 8 == 2) rb = 64'h8000_0000_0000_0000;
      if (k % 8 == 3) ra = {ra[63:16], 16'hFFFF};
      run_op($sformatf("rnd%0d", k), ra, rb, 1'($urandom),
             1'($urandom), (k % 10 == 5) ? 3 : 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ksa_wide_seq.md
# ksa_wide_seq

Multi-word sequential adder/subtractor that drives the team's 16-bit Kogge-Stone adder one word per cycle and chains its carry through a register. It builds 16·WORDS-bit add/subtract from a single adder instance. It sits upstream of the 16-bit adder, supplying operand words and carry-in, and downstream of it, collecting sum words and the final carry. Operands arrive and results leave on valid/ready handshakes.

## Interface
- WORDS, 4: number of 16-bit words per operand; legal range ≥ 1.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept an operand set.
- a  in  16·WORDS  operand A.
- b  in  16·WORDS  operand B.
- ci  in  1  carry-in; ignored when sub=1.
- sub  in  1  1 = compute A−B, 0 = compute A+B+ci.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  16·WORDS  result.
- co  out  1  carry out of the MSB; for sub this is the inverted borrow (1 = no borrow).
- ovf  out  1  two's-complement signed overflow.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, at the edge: capture a into a_reg and (sub ? ~b : b) into b_reg.
  - Set carry_reg = sub ? 1 : ci; idx=0; go to RUN.
- RUN:
  - in_ready=0.
  - The adder receives a_reg word[idx], b_reg word[idx] and carry_reg.
  - Each edge: sum_reg word[idx] ← adder S; carry_reg ← adder Co; idx++.
  - On idx==WORDS−1: additionally co ← adder Co; ovf ← (A_msb == B'_msb) && (S_msb != A_msb), where B' is the possibly inverted B; go to DONE.
- DONE:
  - out_valid=1; sum, co and ovf held stable.
  - On out_ready at the edge: out_valid←0; go to IDLE.
- Word order is LSW first (word 0 = bits 15:0).
- idx width is clog2(WORDS), minimum 1 bit.
- All arithmetic is modulo 2^(16·WORDS); the carry beyond the MSB appears only on co.
- Reset, including mid-RUN or mid-DONE: state=IDLE, idx=0, carry_reg=0, sum=0, co=0, ovf=0, out_valid=0, in_ready=1 from the cycle after reset. An in-flight operation is discarded and produces no output.
- in_valid while not in IDLE is ignored; the upstream must hold its data until in_ready.
- WORDS=1: RUN lasts exactly one cycle.

## Timing
- Accept at edge T.
- RUN occupies edges T+1 … T+WORDS.
- out_valid is high in the cycle after edge T+WORDS, i.e. latency WORDS+1 edges from accept.
- Earliest result handshake is at edge T+WORDS+1; next accept at T+WORDS+2.
- Maximum throughput: one operation per WORDS+2 cycles.
- in_ready and out_valid are never high in the same cycle.
- All outputs are registered.
- The combinational adder path is a single 16-bit adder plus muxing and must close within one cycle.

## Structure
- Shared package ksa_pkg holds:
  - WORD_W = 16.
  - The FSM state enum (IDLE, RUN, DONE).
  - Word-select helper function.
- One instance of sub-module ksa_16bit, driven by the word muxes and carry_reg.
- No other sub-modules.

## Test plan
- WORDS=4, a=0x0000_0000_0000_FFFF, b=1, ci=0, sub=0 -> sum=0x0000_0000_0001_0000, co=0, ovf=0; out_valid first high after edge T+4 (latency 5 edges per Timing).
- a=0xFFFF_FFFF_FFFF_FFFF, b=0, ci=1 -> sum=0, co=1, ovf=0; carry ripples across all 4 words.
- sub=1, a=5, b=7 -> sum=0xFFFF_FFFF_FFFF_FFFE, co=0, ovf=0; then a=7, b=5 -> sum=2, co=1.
- a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=0x8000_0000_0000_0000, ovf=1, co=0; a=0x8000_0000_0000_0000 minus 1 -> sum=0x7FFF_FFFF_FFFF_FFFF, ovf=1.
- Hold out_ready=0 for 10 cycles in DONE -> sum, co, ovf and out_valid stable, in_ready=0, in_valid ignored; release -> IDLE next cycle, new operand accepted the cycle after.
- Assert rst for one cycle at RUN idx=2 -> out_valid never rises for that operation; in_ready=1 and sum=0 the cycle after; a new add of 3+4 returns 7.
